// File: rtl/branch_tracker.sv
// In-order tracker for in-flight conditional branches: retires resolved
// branches to the predictor and redirects/flushes fetch on a mispredict.
module branch_tracker #(
    parameter int  DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             alloc_valid_i,
    input  logic             alloc_pred_taken_i,
    input  logic [31:0]      alloc_target_i,
    input  logic [31:0]      alloc_fallthru_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             resolve_valid_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_taken_i,
    output logic             pred_update_valid_o,
    output logic             pred_update_corr_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [TAG_W:0]   inflight_count_o
);

    localparam int CNT_W = TAG_W + 1;

    typedef struct packed {
        logic        valid;
        logic        resolved;
        logic        pred_taken;
        logic        actual_taken;
        logic [31:0] target;
        logic [31:0] fallthru;
    } entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    entry_t     ent_q [DEPTH];
    state_e     state_q, state_d;
    logic [TAG_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    entry_t head_e, res_e;
    logic   run, head_done, head_mis;
    logic   retire, mispredict;
    logic   alloc_fire, resolve_fire;

    always_comb begin
        head_e       = ent_q[head_q];
        res_e        = ent_q[resolve_tag_i];
        run          = (state_q == RUN);
        head_done    = head_e.valid && head_e.resolved;
        head_mis     = head_e.actual_taken != head_e.pred_taken;
        retire       = run && head_done;
        mispredict   = retire && head_mis;
        // a pending mispredict blocks allocation so the flush sees no new work
        alloc_ready_o = run && (count_q < CNT_W'(DEPTH))
                        && !(head_done && head_mis);
        alloc_fire   = alloc_valid_i && alloc_ready_o;
        resolve_fire = run && resolve_valid_i && res_e.valid
                       && !res_e.resolved && !mispredict;
    end

    assign alloc_tag_o      = tail_q;
    assign inflight_count_o = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (mispredict) state_d = FLUSH;
            FLUSH: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (resolve_fire) begin
                ent_q[resolve_tag_i].resolved     <= 1'b1;
                ent_q[resolve_tag_i].actual_taken <= resolve_taken_i;
            end
            if (retire) begin
                ent_q[head_q].valid <= 1'b0;
                head_q <= head_q + TAG_W'(1);
            end
            if (alloc_fire) begin
                ent_q[tail_q] <= '{
                    valid:        1'b1,
                    resolved:     1'b0,
                    pred_taken:   alloc_pred_taken_i,
                    actual_taken: 1'b0,
                    target:       alloc_target_i,
                    fallthru:     alloc_fallthru_i
                };
                tail_q <= tail_q + TAG_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pred_update_valid_o <= 1'b0;
            pred_update_corr_o  <= 1'b0;
            redirect_valid_o    <= 1'b0;
            flush_o             <= 1'b0;
            redirect_pc_o       <= '0;
        end else begin
            pred_update_valid_o <= retire;
            pred_update_corr_o  <= retire && !head_mis;
            redirect_valid_o    <= mispredict;
            flush_o             <= mispredict;
            if (mispredict) begin
                redirect_pc_o <= head_e.actual_taken ? head_e.target
                                                     : head_e.fallthru;
            end
        end
    end

endmodule

// File: tb/tb_branch_tracker.sv
// Scoreboard bench for branch_tracker against a queue-based program-order model.
module tb_branch_tracker;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             alloc_valid_i;
    logic             alloc_pred_taken_i;
    logic [31:0]      alloc_target_i;
    logic [31:0]      alloc_fallthru_i;
    logic             alloc_ready_o;
    logic [TAG_W-1:0] alloc_tag_o;
    logic             resolve_valid_i;
    logic [TAG_W-1:0] resolve_tag_i;
    logic             resolve_taken_i;
    logic             pred_update_valid_o;
    logic             pred_update_corr_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic [TAG_W:0]   inflight_count_o;

    branch_tracker #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .reset_ni            (reset_ni),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_pred_taken_i  (alloc_pred_taken_i),
        .alloc_target_i      (alloc_target_i),
        .alloc_fallthru_i    (alloc_fallthru_i),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_tag_o         (alloc_tag_o),
        .resolve_valid_i     (resolve_valid_i),
        .resolve_tag_i       (resolve_tag_i),
        .resolve_taken_i     (resolve_taken_i),
        .pred_update_valid_o (pred_update_valid_o),
        .pred_update_corr_o  (pred_update_corr_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .flush_o             (flush_o),
        .inflight_count_o    (inflight_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          tag;
        bit          pt;
        bit          res;
        bit          act;
        logic [31:0] tgt;
        logic [31:0] ft;
    } br_t;

    typedef struct {
        bit          corr;
        bit          redir;
        logic [31:0] pc;
    } exp_t;

    br_t  q[$];
    exp_t sb[$];
    int   next_tag = 0;
    bit   flush_m  = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_upd    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (pred_update_valid_o) begin
            n_upd++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_update: got pulse required none");
            end else begin
                e = sb.pop_front();
                chk("upd_corr", pred_update_corr_o, e.corr);
                chk("redirect_valid", redirect_valid_o, e.redir);
                chk("flush", flush_o, e.redir);
                if (e.redir) chk("redirect_pc", redirect_pc_o, e.pc);
            end
        end else begin
            chk("quiet_outputs",
                {redirect_valid_o, flush_o, pred_update_corr_o}, 0);
        end
    end

    // One cycle: check visible state, drive inputs, advance the model.
    task automatic step(input bit av, input bit pt, input logic [31:0] tgt,
                        input logic [31:0] ft, input bit rv, input int rtag,
                        input bit rtk);
        bit   ready_m;
        bit   do_ret;
        int   idx;
        br_t  b;
        exp_t e;
        @(negedge clk_i);
        ready_m = !flush_m && q.size() < DEPTH &&
                  !(q.size() > 0 && q[0].res && q[0].act != q[0].pt);
        chk("alloc_ready", alloc_ready_o, ready_m);
        chk("inflight_count", inflight_count_o, q.size());
        chk("alloc_tag", alloc_tag_o, next_tag);
        alloc_valid_i      = av;
        alloc_pred_taken_i = pt;
        alloc_target_i     = tgt;
        alloc_fallthru_i   = ft;
        resolve_valid_i    = rv;
        resolve_tag_i      = TAG_W'(rtag);
        resolve_taken_i    = rtk;
        if (flush_m) begin
            flush_m = 0;
            return;
        end
        do_ret = q.size() > 0 && q[0].res;
        if (do_ret && q[0].act != q[0].pt) begin
            e.corr  = 0;
            e.redir = 1;
            e.pc    = q[0].act ? q[0].tgt : q[0].ft;
            sb.push_back(e);
            q.delete();
            next_tag = 0;
            flush_m  = 1;
            return;
        end
        if (rv) begin
            idx = -1;
            foreach (q[i]) if (q[i].tag == rtag && !q[i].res) idx = i;
            if (idx >= 0) begin
                q[idx].res = 1;
                q[idx].act = rtk;
            end
        end
        if (do_ret) begin
            e.corr  = 1;
            e.redir = 0;
            e.pc    = '0;
            sb.push_back(e);
            void'(q.pop_front());
        end
        if (av && ready_m) begin
            b.tag = next_tag;
            b.pt  = pt;
            b.res = 0;
            b.act = 0;
            b.tgt = tgt;
            b.ft  = ft;
            q.push_back(b);
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input bit pt, input logic [31:0] tgt,
                         input logic [31:0] ft);
        step(1, pt, tgt, ft, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input bit tk);
        step(0, 0, 0, 0, 1, tag, tk);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() > 0 || flush_m) && guard < 50) begin
            int k = -1;
            foreach (q[i]) if (!q[i].res && k < 0) k = i;
            if (k >= 0) resolve(q[k].tag, q[k].pt);
            else idle(1);
            guard++;
        end
        chk("drain_bound", guard < 50, 1);
        idle(2);
    endtask

    initial begin
        int up0;
        reset_ni           = 1'b0;
        alloc_valid_i      = 1'b0;
        alloc_pred_taken_i = 1'b0;
        alloc_target_i     = '0;
        alloc_fallthru_i   = '0;
        resolve_valid_i    = 1'b0;
        resolve_tag_i      = '0;
        resolve_taken_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_count", inflight_count_o, 0);
        chk("reset_redirect_pc", redirect_pc_o, 0);
        reset_ni = 1'b1;
        idle(3);

        for (int i = 0; i < 4; i++) alloc(i[0], 32'h1000 + i, 32'h2000 + i);
        idle(1);
        resolve(0, 1'b0);
        idle(2);
        for (int t = 1; t < 4; t++) resolve(t, q[0].pt);
        drain();

        for (int i = 0; i < 3; i++) alloc(1, 32'h300 + i, 32'h400 + i);
        resolve(2, 1);
        resolve(1, 1);
        resolve(0, 1);
        idle(5);

        alloc(0, 32'h100, 32'h44);
        alloc(1, 32'h200, 32'h48);
        resolve(0, 1);
        idle(3);
        alloc(1, 32'h500, 32'h504);
        drain();

        up0 = n_upd;
        for (int i = 0; i < 10; i++) begin
            alloc(0, 32'h600 + i, 32'h700 + i);
            chk("wrap_count_le1", inflight_count_o <= 1, 1);
            resolve(q[q.size()-1].tag, 0);
        end
        idle(3);
        chk("wrap_updates", n_upd - up0, 10);

        for (int c = 0; c < 600; c++) begin
            bit rv = 0;
            int rtag = 0;
            bit rtk = 0;
            int cand[$];
            foreach (q[i]) if (!q[i].res) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
                int k = cand[$urandom_range(cand.size() - 1, 0)];
                rv   = 1;
                rtag = q[k].tag;
                rtk  = q[k].pt ^ ($urandom_range(5, 0) == 0);
            end
            step($urandom_range(2, 0) != 0, 1'($urandom),
                 $urandom, $urandom, rv, rtag, rtk);
        end
        drain();

        for (int i = 0; i < 3; i++) alloc(0, 32'h900 + i, 32'h990 + i);
        resolve(q[0].tag, 1);
        @(negedge clk_i);
        alloc_valid_i   = 1'b0;
        resolve_valid_i = 1'b0;
        #2 reset_ni = 1'b0;
        #1;
        chk("rst_upd_valid", pred_update_valid_o, 0);
        chk("rst_redirect", redirect_valid_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_count", inflight_count_o, 0);
        q.delete();
        sb.delete();
        next_tag = 0;
        flush_m  = 0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        idle(5);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
